// File: rtl/bus_region_ctrl.sv
// ============================================================================
// Module   : bus_region_ctrl
// Brief    : Address-region decoder and bus-cycle controller that generates chip
//            selects, strobes, wait states, ready and a sticky error report.
// Revision : 1.0
// ============================================================================
`default_nettype none

module bus_region_ctrl #(
    parameter int NREG   = 4,
    parameter int AW     = 23,
    parameter int WSW    = 4,
    parameter int TO_CYC = 255
) (
    input  logic                 clk,
    input  logic                 _rst,
    input  logic [AW-1:0]        a,
    input  logic                 _ads,
    input  logic                 _bhe,
    input  logic                 _ble,
    input  logic                 wr,
    input  logic                 dc,
    input  logic                 mio,
    input  logic [NREG*AW-1:0]   reg_base,
    input  logic [NREG*AW-1:0]   reg_mask,
    input  logic [NREG*WSW-1:0]  reg_ws,
    input  logic [NREG-1:0]      reg_io,
    input  logic                 ext_rdy,
    input  logic                 err_clr,
    output logic [NREG-1:0]      cs,
    output logic                 oe,
    output logic                 we,
    output logic [1:0]           be,
    output logic                 _ready,
    output logic                 busy,
    output logic                 err,
    output logic [1:0]           err_code,
    output logic [AW-1:0]        err_addr
);

    localparam int             TW      = (TO_CYC > 1) ? $clog2(TO_CYC + 1) : 1;
    localparam logic [WSW-1:0] WS_EXT  = {WSW{1'b1}};
    localparam logic [TW-1:0]  TO_LAST = TW'(TO_CYC - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, READY = 2'd2} state_t;

    state_t          state_q, state_d;
    logic [NREG-1:0] cs_q, cs_d;
    logic            oe_q, oe_d, we_q, we_d;
    logic [1:0]      be_q, be_d;
    logic            ready_n_q, ready_n_d, busy_q, busy_d;
    logic            err_q, err_d;
    logic [1:0]      code_q, code_d;
    logic [AW-1:0]   eaddr_q, eaddr_d, addr_q, addr_d;
    logic            ext_q, ext_d, unmap_q, unmap_d;
    logic [WSW-1:0]  cnt_q, cnt_d;
    logic [TW-1:0]   to_q, to_d;

    logic            hit, halt, mapped, go, new_err;
    logic [NREG-1:0] hit_cs;
    logic [WSW-1:0]  hit_ws;
    logic [1:0]      new_code;

    // Descending scan so the lowest matching region index is the last one written.
    always_comb begin
        hit    = 1'b0;
        hit_cs = '0;
        hit_ws = '0;
        for (int i = NREG - 1; i >= 0; i--) begin
            if ((((a ^ reg_base[i*AW +: AW]) & reg_mask[i*AW +: AW]) == '0) &&
                (reg_io[i] == ~mio)) begin
                hit       = 1'b1;
                hit_cs    = '0;
                hit_cs[i] = 1'b1;
                hit_ws    = reg_ws[i*WSW +: WSW];
            end
        end
    end

    assign halt   = mio & ~dc & wr;
    assign mapped = hit & ~halt;

    always_comb begin
        state_d   = state_q;
        cs_d      = cs_q;
        oe_d      = oe_q;
        we_d      = we_q;
        be_d      = be_q;
        ready_n_d = 1'b1;
        err_d     = err_q;
        code_d    = code_q;
        eaddr_d   = eaddr_q;
        addr_d    = addr_q;
        ext_d     = ext_q;
        unmap_d   = unmap_q;
        cnt_d     = cnt_q;
        to_d      = to_q;
        go        = 1'b0;
        new_err   = 1'b0;
        new_code  = 2'b00;

        if (state_q == ACCESS) begin
            if (ext_q) begin
                // ext_rdy is tested first so a coincident expiry completes cleanly.
                if (ext_rdy) begin
                    go = 1'b1;
                end else if (to_q == TO_LAST) begin
                    go       = 1'b1;
                    new_err  = 1'b1;
                    new_code = 2'b10;
                end else begin
                    to_d = to_q + 1'b1;
                end
            end else if (cnt_q == '0) begin
                go = 1'b1;
                if (unmap_q) begin
                    new_err  = 1'b1;
                    new_code = 2'b01;
                end
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
            if (go) begin
                state_d   = READY;
                ready_n_d = 1'b0;
                we_d      = 1'b0;
            end
        end else begin
            state_d = IDLE;
            cs_d    = '0;
            oe_d    = 1'b0;
            we_d    = 1'b0;
            if (!_ads) begin
                state_d = ACCESS;
                addr_d  = a;
                be_d    = {~_bhe, ~_ble};
                cs_d    = mapped ? hit_cs : '0;
                oe_d    = mapped & ~wr;
                we_d    = mapped & wr;
                cnt_d   = mapped ? hit_ws : '0;
                ext_d   = mapped && (hit_ws == WS_EXT);
                unmap_d = ~hit & ~halt;
                to_d    = '0;
            end
        end

        if (err_clr) begin
            err_d   = 1'b0;
            code_d  = 2'b00;
            eaddr_d = '0;
        end
        if (new_err && (!err_q || err_clr)) begin
            err_d   = 1'b1;
            code_d  = new_code;
            eaddr_d = addr_q;
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            state_q   <= IDLE;
            cs_q      <= '0;
            oe_q      <= 1'b0;
            we_q      <= 1'b0;
            be_q      <= 2'b00;
            ready_n_q <= 1'b1;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            code_q    <= 2'b00;
            eaddr_q   <= '0;
            addr_q    <= '0;
            ext_q     <= 1'b0;
            unmap_q   <= 1'b0;
            cnt_q     <= '0;
            to_q      <= '0;
        end else begin
            state_q   <= state_d;
            cs_q      <= cs_d;
            oe_q      <= oe_d;
            we_q      <= we_d;
            be_q      <= be_d;
            ready_n_q <= ready_n_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            code_q    <= code_d;
            eaddr_q   <= eaddr_d;
            addr_q    <= addr_d;
            ext_q     <= ext_d;
            unmap_q   <= unmap_d;
            cnt_q     <= cnt_d;
            to_q      <= to_d;
        end
    end

    assign cs       = cs_q;
    assign oe       = oe_q;
    assign we       = we_q;
    assign be       = be_q;
    assign _ready   = ready_n_q;
    assign busy     = busy_q;
    assign err      = err_q;
    assign err_code = code_q;
    assign err_addr = eaddr_q;

endmodule

`default_nettype wire
